// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Optional feature macro used elsewhere in this slice: SIGNED_CMP_EN.
package seq_cmp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CMP  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      LT = 2'd0,
      EQ = 2'd1,
      GT = 2'd2
   } result_t;

   // Width of the cycle counter: it must hold the values 0..N.
   function automatic int calc_cw(input int width, input int digit);
      return $clog2(width / digit + 1);
   endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand/result bundle of the sequential magnitude comparator.
// With SIGNED_CMP_EN defined the bundle also carries signed_mode.
interface seq_magnitude_comparator_if
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4,
   parameter int CW    = calc_cw(WIDTH, DIGIT)
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SIGNED_CMP_EN
   logic             signed_mode;
`endif
   logic             busy;
   logic             done;
   logic             a_lt_b;
   logic             a_eq_b;
   logic             a_gt_b;
   logic [CW-1:0]    cycles;

`ifdef SIGNED_CMP_EN
   modport master (
      output start, a, b, signed_mode,
      input  busy, done, a_lt_b, a_eq_b, a_gt_b, cycles
   );
   modport slave (
      input  start, a, b, signed_mode,
      output busy, done, a_lt_b, a_eq_b, a_gt_b, cycles
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, a_lt_b, a_eq_b, a_gt_b, cycles
   );
   modport slave (
      input  start, a, b,
      output busy, done, a_lt_b, a_eq_b, a_gt_b, cycles
   );
`endif

endinterface

// File: rtl/seq_magnitude_comparator_chunk_cmp.sv
// Combinational unsigned compare of one DIGIT-bit chunk pair.
module chunk_cmp #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   output logic             lt_o,
   output logic             eq_o,
   output logic             gt_o
);

   assign lt_o = (a_i <  b_i);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per clock,
// MSB chunk first, and stops on the first unequal chunk.
// Optional feature macro: SIGNED_CMP_EN (adds two's-complement compare).
module seq_magnitude_comparator
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   seq_magnitude_comparator_if.slave bus
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = calc_cw(WIDTH, DIGIT);

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] a_ld, b_ld;
   logic [CW-1:0]    idx_q;
   logic [CW-1:0]    cyc_q;
   logic             busy_q, done_q;
   logic             lt_q, eq_q, gt_q;
   logic             head_lt, head_eq, head_gt;
   result_t          res_c;
   logic             accept, advance, last_chunk;

   chunk_cmp #(.DIGIT(DIGIT)) u_chunk_cmp (
      .a_i  (a_sh_q[WIDTH-1 -: DIGIT]),
      .b_i  (b_sh_q[WIDTH-1 -: DIGIT]),
      .lt_o (head_lt),
      .eq_o (head_eq),
      .gt_o (head_gt)
   );

   // Encode the head-chunk verdict and the capture/shift qualifiers.
   always_comb begin
      res_c = EQ;
      if (head_lt) begin
         res_c = LT;
      end else if (head_gt) begin
         res_c = GT;
      end else if (!head_eq) begin
         res_c = EQ;
      end
      last_chunk = (idx_q == CW'(N - 1));
      accept     = (state_q == IDLE) && bus.start;
      advance    = (state_q == CMP) && (res_c == EQ) && !last_chunk;
   end

   // Operand load value; signed mode flips the MSB so an unsigned walk gives signed order.
   always_comb begin
      a_ld = bus.a;
      b_ld = bus.b;
`ifdef SIGNED_CMP_EN
      if (bus.signed_mode) begin
         a_ld[WIDTH-1] = ~bus.a[WIDTH-1];
         b_ld[WIDTH-1] = ~bus.b[WIDTH-1];
      end
`endif
   end

   // Shift-register next state: load on accept, move up one chunk while equal.
   always_comb begin
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      if (accept) begin
         a_sh_d = a_ld;
         b_sh_d = b_ld;
      end else if (advance) begin
         a_sh_d = a_sh_q << DIGIT;
         b_sh_d = b_sh_q << DIGIT;
      end
   end

   // Operand shift registers are pure data and carry no reset.
   always_ff @(posedge clk) begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
   end

   // Control FSM with registered handshake, result flags and cycle count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         cyc_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CMP;
               end
            end
            CMP: begin
               if (res_c != EQ) begin
                  lt_q    <= (res_c == LT);
                  gt_q    <= (res_c == GT);
                  eq_q    <= 1'b0;
                  cyc_q   <= idx_q + CW'(1);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (last_chunk) begin
                  lt_q    <= 1'b0;
                  gt_q    <= 1'b0;
                  eq_q    <= 1'b1;
                  cyc_q   <= CW'(N);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  idx_q <= idx_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.a_lt_b = lt_q;
   assign bus.a_eq_b = eq_q;
   assign bus.a_gt_b = gt_q;
   assign bus.cycles = cyc_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4).
// Build with SIGNED_CMP_EN defined to exercise the signed compare.
module tb_seq_magnitude_comparator;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   seq_magnitude_comparator_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) bif ();

   seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   // Drives one operation and reports the cycle offset of done (0 = timeout)
   // and whether busy was high in every cycle before done and low with done.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                         output int lat, output bit busy_ok);
      bif.a = av;
      bif.b = bv;
`ifdef SIGNED_CMP_EN
      bif.signed_mode = sm;
`endif
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      bif.a = 16'hDEAD;
      bif.b = 16'hBEEF;
`ifdef SIGNED_CMP_EN
      bif.signed_mode = ~sm;
`endif
      lat = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         if (bif.done) begin
            lat = k;
            if (bif.busy) busy_ok = 1'b0;
            break;
         end
         if (!bif.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
      checks++;
      if (bif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bif.done); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b});
      end
      checks++;
      if (bif.cycles !== 3'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", bif.cycles); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_equal();
      int lat; bit bok;
      run_op(16'h1234, 16'h1234, 1'b0, lat, bok);
      checks++;
      if (lat !== 5) begin failures++; $display("FAIL eq_latency got=%0d exp=5", lat); end
      checks++;
      if (!bok) begin failures++; $display("FAIL eq_busy got=0 exp=1"); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b} !== 3'b010) begin
         failures++; $display("FAIL eq_flags got=%b exp=010", {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b});
      end
      checks++;
      if (bif.cycles !== 3'd4) begin failures++; $display("FAIL eq_cycles got=%0d exp=4", bif.cycles); end
      @(posedge clk); #1;
      checks++;
      if ({bif.done, bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles} !== {1'b0, 3'b010, 3'd4}) begin
         failures++; $display("FAIL eq_hold got=%b exp=0010100",
                              {bif.done, bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles});
      end
   endtask

   task automatic test_msb_exit();
      int lat; bit bok;
      run_op(16'h8000, 16'h7FFF, 1'b0, lat, bok);
      checks++;
      if (lat !== 2 || !bok) begin failures++; $display("FAIL msb_latency got=%0d exp=2 busy_ok=%0d", lat, bok); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b} !== 3'b001) begin
         failures++; $display("FAIL msb_flags got=%b exp=001", {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b});
      end
      checks++;
      if (bif.cycles !== 3'd1) begin failures++; $display("FAIL msb_cycles got=%0d exp=1", bif.cycles); end
   endtask

   task automatic test_lsb_decides();
      int lat; bit bok;
      run_op(16'h12F4, 16'h12F5, 1'b0, lat, bok);
      checks++;
      if (lat !== 5 || !bok) begin failures++; $display("FAIL lsb_latency got=%0d exp=5 busy_ok=%0d", lat, bok); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b} !== 3'b100) begin
         failures++; $display("FAIL lsb_flags got=%b exp=100", {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b});
      end
      checks++;
      if (bif.cycles !== 3'd4) begin failures++; $display("FAIL lsb_cycles got=%0d exp=4", bif.cycles); end
   endtask

   task automatic test_mid_chunk();
      int lat; bit bok;
      run_op(16'h0F00, 16'h0E00, 1'b0, lat, bok);
      checks++;
      if (lat !== 3 || !bok) begin failures++; $display("FAIL mid_latency got=%0d exp=3 busy_ok=%0d", lat, bok); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles} !== {3'b001, 3'd2}) begin
         failures++; $display("FAIL mid_result got=%b exp=001010",
                              {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles});
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      bif.a = 16'h1234;
      bif.b = 16'h1234;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      @(posedge clk); #1;
      bif.a = 16'h0001;
      bif.b = 16'h0002;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      cnt = 3;
      while (!bif.done && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++;
      if (cnt !== 5) begin failures++; $display("FAIL busy_start_done_at got=%0d exp=5", cnt); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b} !== 3'b010) begin
         failures++; $display("FAIL busy_start_flags got=%b exp=010", {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b});
      end
      bif.a = 16'h0001;
      bif.b = 16'h0002;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      cnt++;
      while (!bif.done && cnt < 30) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++;
      if (cnt !== 10) begin failures++; $display("FAIL b2b_done_at got=%0d exp=10", cnt); end
      checks++;
      if ({bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles} !== {3'b100, 3'd4}) begin
         failures++; $display("FAIL b2b_result got=%b exp=100100",
                              {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles});
      end
   endtask

   task automatic test_reset_mid_op();
      bit saw_done;
      bif.a = 16'h1234;
      bif.b = 16'h1234;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({bif.busy, bif.done, bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles} !== 8'd0) begin
         failures++; $display("FAIL rst_mid_outputs got=%b exp=00000000",
                              {bif.busy, bif.done, bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles});
      end
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (bif.done || bif.busy) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (saw_done) begin failures++; $display("FAIL rst_mid_quiet got=1 exp=0"); end
   endtask

   task automatic test_signed();
      int lat; bit bok;
      run_op(16'h8000, 16'h0001, 1'b0, lat, bok);
      checks++;
      if (lat !== 2 || {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles} !== {3'b001, 3'd1}) begin
         failures++; $display("FAIL unsigned_8000 got=lat%0d/%b exp=lat2/001001",
                              lat, {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles});
      end
`ifdef SIGNED_CMP_EN
      run_op(16'h8000, 16'h0001, 1'b1, lat, bok);
      checks++;
      if (lat !== 2 || {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles} !== {3'b100, 3'd1}) begin
         failures++; $display("FAIL signed_8000 got=lat%0d/%b exp=lat2/100001",
                              lat, {bif.a_lt_b, bif.a_eq_b, bif.a_gt_b, bif.cycles});
      end
`endif
   endtask

   initial begin
      bif.start = 1'b0;
      bif.a = '0;
      bif.b = '0;
`ifdef SIGNED_CMP_EN
      bif.signed_mode = 1'b0;
`endif
      test_reset();
      test_equal();
      test_msb_exit();
      test_lsb_decides();
      test_mid_chunk();
      test_back_to_back();
      test_reset_mid_op();
      test_signed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
